pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_irq_sync.sv | 28 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: next-PC select encodings and
// the default reset/exception vectors.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pcsrc_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0008;

endpackage

// File: rtl/pc_sequencer_irq_sync.sv
// Two-flop synchroniser for the asynchronous irq line, followed by a
// rising-edge detector on the synchronised level.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      meta_p0 <= irq;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next PC from sequential, branch,
// jump and register-jump sources, and redirects on illegal ops and interrupts.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  input  logic        illop,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [6:0]  rom_addr,
  output logic [31:0] pc_plus4,
  output logic        supervisor,
  output logic        kill,
  output logic        epc_we,
  output logic [31:0] epc
);

  // Bit 31 is the mode bit; address arithmetic wraps within the low 31 bits.
  function automatic logic [31:0] pc_add(input logic [31:0] base, input logic [30:0] inc);
    pc_add = {base[31], base[30:0] + inc};
  endfunction

  logic        irq_rise;
  logic        irq_pending;
  logic        irq_pending_next;
  logic        take_irq;
  logic [31:0] pc_next;
  logic [31:0] br_target;
  logic        unused_off_bits;

  irq_sync u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .rise  (irq_rise)
  );

  assign rom_addr   = pc[8:2];
  assign pc_plus4   = pc_add(pc, 31'd4);
  assign supervisor = pc[31];
  assign br_target  = pc_add(pc_plus4, {branch_off[28:0], 2'b00});
  // Offset bits above 28 shift out of the 31-bit address space.
  assign unused_off_bits = ^branch_off[31:29];

  assign take_irq         = irq_pending & ~pc[31] & ~stall & ~illop;
  // A fresh edge in the same cycle the interrupt is taken re-arms pending.
  assign irq_pending_next = irq_rise | (irq_pending & ~take_irq);

  always_comb begin
    pc_next = pc_plus4;
    kill    = 1'b0;
    epc_we  = 1'b0;
    epc     = '0;
    if (stall) begin
      pc_next = pc;
    end else if (illop) begin
      pc_next = ILLOP_VEC;
      kill    = 1'b1;
      epc_we  = 1'b1;
      epc     = pc_plus4;
    end else if (take_irq) begin
      pc_next = IRQ_VEC;
      kill    = 1'b1;
      epc_we  = 1'b1;
      epc     = pc;
    end else begin
      case (pcsrc_e'(pcsrc))
        PC_SEQ:  pc_next = pc_plus4;
        PC_BR:   pc_next = branch_taken ? br_target : pc_plus4;
        PC_J:    pc_next = {pc[31], pc_plus4[30:28], jump_idx, 2'b00};
        PC_JR:   pc_next = {pc[31] & jr_target[31], jr_target[30:0]};
        default: pc_next = pc_plus4;
      endcase
    end
    // Reset aborts any redirect in flight.
    if (!reset) begin
      kill   = 1'b0;
      epc_we = 1'b0;
      epc    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_VEC;
      irq_pending <= 1'b0;
    end else begin
      pc          <= pc_next;
      irq_pending <= irq_pending_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset, jumps, branches, interrupts,
// illegal-op traps and stalls against hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pcsrc;
  logic        branch_taken;
  logic [31:0] branch_off;
  logic [25:0] jump_idx;
  logic [31:0] jr_target;
  logic        illop;
  logic        irq;
  logic [31:0] pc;
  logic [6:0]  rom_addr;
  logic [31:0] pc_plus4;
  logic        supervisor;
  logic        kill;
  logic        epc_we;
  logic [31:0] epc;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pcsrc        (pcsrc),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump_idx     (jump_idx),
    .jr_target    (jr_target),
    .illop        (illop),
    .irq          (irq),
    .pc           (pc),
    .rom_addr     (rom_addr),
    .pc_plus4     (pc_plus4),
    .supervisor   (supervisor),
    .kill         (kill),
    .epc_we       (epc_we),
    .epc          (epc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_jr(input logic [31:0] tgt);
    pcsrc = 2'd3; jr_target = tgt;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; pcsrc = 2'd0; branch_taken = 1'b0;
    branch_off = '0; jump_idx = '0; jr_target = '0; illop = 1'b0; irq = 1'b0;
    #12;
    total++;
    if ({pc, rom_addr} !== {32'h8000_0000, 7'h00}) begin
      bad++; $display("FAIL reset_pc: pc=%h rom=%h want 80000000/00", pc, rom_addr);
    end
    total++;
    if ({kill, epc_we, epc} !== {2'b00, 32'h0}) begin
      bad++; $display("FAIL reset_redirect: kill=%b we=%b epc=%h want 0/0/0", kill, epc_we, epc);
    end
    @(posedge clk); #1; reset = 1'b1; #1;
    total++;
    if ({pc, rom_addr, supervisor} !== {32'h8000_0000, 7'h00, 1'b1}) begin
      bad++; $display("FAIL release_pc: pc=%h rom=%h sup=%b want 80000000/00/1", pc, rom_addr, supervisor);
    end
  endtask

  task automatic test_jump();
    pcsrc = 2'd2; jump_idx = 26'h4A; #1;
    total++;
    if (pc_plus4 !== 32'h8000_0004) begin
      bad++; $display("FAIL pc_plus4: got %h want 80000004", pc_plus4);
    end
    step();
    total++;
    if ({pc, rom_addr} !== {32'h8000_0128, 7'h4A}) begin
      bad++; $display("FAIL jump_pc: pc=%h rom=%h want 80000128/4a", pc, rom_addr);
    end
  endtask

  task automatic test_branch();
    drive_jr(32'h0000_00A8); step();
    total++;
    if ({pc, supervisor} !== {32'h0000_00A8, 1'b0}) begin
      bad++; $display("FAIL jr_to_user: pc=%h sup=%b want 000000a8/0", pc, supervisor);
    end
    pcsrc = 2'd1; branch_taken = 1'b1; branch_off = 32'hFFFF_FFF8; step();
    total++;
    if (pc !== 32'h0000_008C) begin
      bad++; $display("FAIL branch_taken: got %h want 0000008c", pc);
    end
    drive_jr(32'h0000_00A8); step();
    pcsrc = 2'd1; branch_taken = 1'b0; step();
    total++;
    if (pc !== 32'h0000_00AC) begin
      bad++; $display("FAIL branch_not_taken: got %h want 000000ac", pc);
    end
    drive_jr(32'h7FFF_FFFC); step();
    pcsrc = 2'd0; #1;
    total++;
    if (pc_plus4 !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4);
    end
    step();
    total++;
    if (pc !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_seq: got %h want 00000000", pc);
    end
  endtask

  task automatic test_irq_user();
    int n;
    drive_jr(32'h0000_0090); step();
    pcsrc = 2'd2; jump_idx = 26'h24;
    irq = 1'b1; step(); n = 1; irq = 1'b0;
    while (!kill && n < 8) begin
      step(); n++;
    end
    total++;
    if (n !== 3) begin
      bad++; $display("FAIL irq_latency: took %0d cycles want 3", n);
    end
    total++;
    if ({kill, epc_we, epc, pc} !== {2'b11, 32'h0000_0090, 32'h0000_0090}) begin
      bad++; $display("FAIL irq_take: kill=%b we=%b epc=%h pc=%h want 1/1/90/90", kill, epc_we, epc, pc);
    end
    step();
    total++;
    if ({pc, kill} !== {32'h8000_0004, 1'b0}) begin
      bad++; $display("FAIL irq_vec: pc=%h kill=%b want 80000004/0", pc, kill);
    end
  endtask

  task automatic test_irq_supervisor();
    pcsrc = 2'd2; jump_idx = 26'h50; step();
    irq = 1'b1; step(); irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({pc, kill, epc_we} !== {32'h8000_0140, 2'b00}) begin
        bad++; $display("FAIL sup_hold%0d: pc=%h kill=%b we=%b want 80000140/0/0", i, pc, kill, epc_we);
      end
    end
    drive_jr(32'h0000_0090); step();
    total++;
    if ({pc, kill, epc_we, epc} !== {32'h0000_0090, 2'b11, 32'h0000_0090}) begin
      bad++; $display("FAIL sup_return: pc=%h kill=%b we=%b epc=%h want 90/1/1/90", pc, kill, epc_we, epc);
    end
    step();
    total++;
    if (pc !== 32'h8000_0004) begin
      bad++; $display("FAIL sup_irq_vec: got %h want 80000004", pc);
    end
  endtask

  task automatic test_jr_illop();
    drive_jr(32'h0000_0010); step();
    drive_jr(32'h8000_0000); step();
    total++;
    if ({pc, supervisor} !== {32'h0000_0000, 1'b0}) begin
      bad++; $display("FAIL jr_no_priv: pc=%h sup=%b want 00000000/0", pc, supervisor);
    end
    drive_jr(32'h0000_0000);
    irq = 1'b1; step(); irq = 1'b0;
    step(); step();
    illop = 1'b1; #1;
    total++;
    if ({kill, epc_we, epc} !== {2'b11, 32'h0000_0004}) begin
      bad++; $display("FAIL illop_epc: kill=%b we=%b epc=%h want 1/1/00000004", kill, epc_we, epc);
    end
    step(); illop = 1'b0;
    total++;
    if (pc !== 32'h8000_0008) begin
      bad++; $display("FAIL illop_vec: got %h want 80000008", pc);
    end
    drive_jr(32'h0000_0040); #1;
    total++;
    if (kill !== 1'b0) begin
      bad++; $display("FAIL illop_sup_kill: got %b want 0", kill);
    end
    step();
    total++;
    if ({pc, kill, epc} !== {32'h0000_0040, 1'b1, 32'h0000_0040}) begin
      bad++; $display("FAIL pending_kept: pc=%h kill=%b epc=%h want 40/1/40", pc, kill, epc);
    end
    step();
  endtask

  task automatic test_stall();
    pcsrc = 2'd2; jump_idx = 26'h1;
    irq = 1'b1; step(); irq = 1'b0;
    step(); step();
    drive_jr(32'h0000_0020); step();
    stall = 1'b1; #1;
    total++;
    if ({pc, kill, epc_we} !== {32'h0000_0020, 2'b00}) begin
      bad++; $display("FAIL stall_entry: pc=%h kill=%b we=%b want 20/0/0", pc, kill, epc_we);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({pc, kill} !== {32'h0000_0020, 1'b0}) begin
        bad++; $display("FAIL stall_hold%0d: pc=%h kill=%b want 20/0", i, pc, kill);
      end
    end
    stall = 1'b0; #1;
    total++;
    if ({kill, epc_we, epc} !== {2'b11, 32'h0000_0020}) begin
      bad++; $display("FAIL stall_release: kill=%b we=%b epc=%h want 1/1/20", kill, epc_we, epc);
    end
    step();
    total++;
    if (pc !== 32'h8000_0004) begin
      bad++; $display("FAIL stall_irq_vec: got %h want 80000004", pc);
    end
  endtask

  task automatic test_reset_mid_redirect();
    pcsrc = 2'd0; illop = 1'b1; #1;
    total++;
    if (kill !== 1'b1) begin
      bad++; $display("FAIL pre_abort_kill: got %b want 1", kill);
    end
    reset = 1'b0; #1;
    total++;
    if ({pc, kill, epc_we, epc} !== {32'h8000_0000, 2'b00, 32'h0}) begin
      bad++; $display("FAIL abort: pc=%h kill=%b we=%b epc=%h want 80000000/0/0/0", pc, kill, epc_we, epc);
    end
    step(); step();
    reset = 1'b1; illop = 1'b0; #1;
    total++;
    if (rom_addr !== 7'h00) begin
      bad++; $display("FAIL first_fetch: rom=%h want 00", rom_addr);
    end
    step();
    total++;
    if (pc !== 32'h8000_0004) begin
      bad++; $display("FAIL post_reset_seq: got %h want 80000004", pc);
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_branch();
    test_irq_user();
    test_irq_supervisor();
    test_jr_illop();
    test_stall();
    test_reset_mid_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
